sram_sp_be_ctrl: RTL and testbench

//  Parametrised single-port SRAM with byte-masked writes and a valid/ready

---
 rtl/sram_sp_be_ctrl.sv | 83 ++++++++
 tb/tb_sram_sp_be_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sram_sp_be_ctrl.sv
// sram_sp_be_ctrl: single-port SRAM with byte-masked writes, valid/ready request/response and in-order response buffer
// Ports: CLK/RST (sync, active-high); REQ_VALID/REQ_READY/REQ_WE/REQ_BEN/REQ_A/REQ_D request channel;
//        RSP_VALID/RSP_READY/RSP_Q/RSP_ERR read response channel (RSP_ERR flags address >= DEPTH).
// Option: define SRAM_OUTREG_EN to add a register stage on array read data (latency 2, 3-entry buffer).
module sram_sp_be_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [DATA_W/8-1:0] REQ_BEN,
  input  logic [ADDR_W-1:0] REQ_A,
  input  logic [DATA_W-1:0] REQ_D,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_Q,
  output logic              RSP_ERR
);
`ifdef SRAM_OUTREG_EN
  localparam int NBUF = 3;
`else
  localparam int NBUF = 2;
`endif
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] fifo_q [NBUF];
  logic              fifo_e [NBUF];
  logic [1:0]        cnt, rd_p, wr_p;
  logic [2:0]        occ;
  logic              acc, rd_acc, oor, pop, push, push_e, inflight;
  logic [DATA_W-1:0] rd_q, push_q;
  assign oor = 32'(REQ_A) >= 32'(DEPTH);
  assign rd_q = oor ? '0 : mem[REQ_A];
  assign acc = REQ_VALID & REQ_READY;
  assign rd_acc = acc & ~REQ_WE;
  assign RSP_VALID = cnt != 2'd0;
  assign RSP_Q = RSP_VALID ? fifo_q[rd_p] : '0;
  assign RSP_ERR = RSP_VALID & fifo_e[rd_p];
  assign pop = RSP_VALID & RSP_READY;
  // Credit check: everything that will land in the buffer must fit after this cycle's pop.
  assign occ = 3'(cnt) + 3'(inflight) - 3'(pop);
  assign REQ_READY = ~RST & (occ < 3'(NBUF));
`ifdef SRAM_OUTREG_EN
  logic              p_v, p_e;
  logic [DATA_W-1:0] p_q;
  always_ff @(posedge CLK) begin
    p_v <= RST ? 1'b0 : rd_acc;
    p_q <= rd_q;
    p_e <= oor;
  end
  assign push = p_v;
  assign push_q = p_q;
  assign push_e = p_e;
  assign inflight = p_v;
`else
  assign push = rd_acc;
  assign push_q = rd_q;
  assign push_e = oor;
  assign inflight = 1'b0;
`endif
  always_ff @(posedge CLK)
    if (acc && REQ_WE && !oor)
      for (int i = 0; i < DATA_W/8; i++)
        if (REQ_BEN[i]) mem[REQ_A][8*i +: 8] <= REQ_D[8*i +: 8];
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      rd_p <= '0;
      wr_p <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_p] <= push_q;
        fifo_e[wr_p] <= push_e;
        wr_p <= (wr_p == 2'(NBUF-1)) ? 2'd0 : wr_p + 2'd1;
      end
      if (pop) rd_p <= (rd_p == 2'(NBUF-1)) ? 2'd0 : rd_p + 2'd1;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_sram_sp_be_ctrl.sv
// tb_sram_sp_be_ctrl: directed and random stimulus against a queue-based behavioural model
module tb_sram_sp_be_ctrl;
  localparam int DEPTH = 6000;
`ifdef SRAM_OUTREG_EN
  localparam int LAT = 2;
  localparam int NBUF = 3;
`else
  localparam int LAT = 1;
  localparam int NBUF = 2;
`endif
  typedef struct {logic [31:0] q; logic e; int t;} rsp_t;
  rsp_t q[$];
  logic [31:0] popped[$];
  logic [31:0] mdl [0:DEPTH-1];
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, pop_cyc = 0;
  bit chk_en = 0, last_acc, last_pop, dut_v;
  logic [31:0] last_q;
  logic last_e;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0, rsp_ready = 1;
  logic [3:0] req_ben = 0;
  logic [12:0] req_a = 0;
  logic [31:0] req_d = 0;
  logic REQ_READY, RSP_VALID, RSP_ERR;
  logic [31:0] RSP_Q;
  always #5 clk = ~clk;
  sram_sp_be_ctrl #(.DATA_W(32), .ADDR_W(13), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(REQ_READY), .REQ_WE(req_we),
    .REQ_BEN(req_ben), .REQ_A(req_a), .REQ_D(req_d), .RSP_VALID(RSP_VALID),
    .RSP_READY(rsp_ready), .RSP_Q(RSP_Q), .RSP_ERR(RSP_ERR));
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", n, got, exp, cyc);
    end
  endtask
  // One clock: compare DUT against the model, then advance the model by the spec rules.
  task automatic step();
    bit ev, er;
    int a;
    rsp_t r;
    #1;
    ev = q.size() > 0 && q[0].t <= cyc;
    last_pop = ev && rsp_ready;
    er = !rst && (q.size() - int'(last_pop)) < NBUF;
    dut_v = RSP_VALID;
    if (chk_en) begin
      chk("req_ready", 32'(REQ_READY), 32'(er));
      chk("rsp_valid", 32'(RSP_VALID), 32'(ev));
      if (ev) begin
        chk("rsp_q", RSP_Q, q[0].q);
        chk("rsp_err", 32'(RSP_ERR), 32'(q[0].e));
      end
    end
    last_acc = req_valid && er;
    if (last_pop) begin
      last_q = RSP_Q;
      last_e = RSP_ERR;
      pop_cyc = cyc;
      popped.push_back(RSP_Q);
    end
    if (last_acc) acc_cyc = cyc;
    a = int'(req_a);
    if (rst) q.delete();
    else begin
      if (last_pop) r = q.pop_front();
      if (last_acc && req_we && a < DEPTH)
        for (int i = 0; i < 4; i++) if (req_ben[i]) mdl[a][8*i +: 8] = req_d[8*i +: 8];
      if (last_acc && !req_we)
        q.push_back('{q: (a < DEPTH) ? mdl[a] : 32'h0, e: a >= DEPTH, t: cyc + LAT});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic req(bit we, int a, logic [31:0] d, logic [3:0] ben);
    int n = 0;
    req_valid = 1; req_we = we; req_a = 13'(a); req_d = d; req_ben = ben;
    do begin step(); n++; end while (!last_acc && n < 20);
    req_valid = 0;
    if (!last_acc) begin
      checks++; errors++;
      $display("FAIL req_timeout addr %0d not accepted in 20 cycles", a);
    end
  endtask
  task automatic drain();
    int n = 0;
    rsp_ready = 1;
    while (q.size() > 0 && n < 40) begin step(); n++; end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout %0d responses outstanding, 0 required", q.size());
    end
  endtask
  initial begin
    int n_acc, idx, run, best, a;
    step(); step();
    rst = 0;
    chk_en = 1;
    for (int i = 0; i < 16; i++) req(1, i, 32'hC0DE0000 + 32'(i), 4'hF);
    req(1, 5998, 32'hC0DE0000 + 32'd5998, 4'hF);
    req(1, 5999, 32'hC0DE0000 + 32'd5999, 4'hF);
    // reset held with a write pending
    rst = 1; req_valid = 1; req_we = 1; req_a = 7; req_d = 32'hFFFFFFFF; req_ben = 4'hF;
    repeat (3) step();
    rst = 0; req_valid = 0;
    chk("reset_rsp_valid", 32'(RSP_VALID), 0);
    chk("reset_rsp_q", RSP_Q, 0);
    chk("reset_rsp_err", 32'(RSP_ERR), 0);
    req(0, 7, 0, 0); drain();
    chk("reset_no_write", last_q, 32'hC0DE0007);
    // byte mask
    req(1, 5, 32'hAABBCCDD, 4'b1111);
    req(1, 5, 32'h11223344, 4'b0101);
    req(0, 5, 0, 0); drain();
    chk("bytemask_q", last_q, 32'hAA22CC44);
    chk("bytemask_err", 32'(last_e), 0);
    chk("read_latency", 32'(pop_cyc - acc_cyc), 32'(LAT));
    // backpressure
    rsp_ready = 0; n_acc = 0; idx = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1; req_we = 0; req_a = 13'(idx);
      step();
      if (last_acc) begin n_acc++; idx++; end
    end
    req_valid = 0;
    chk("bp_accepts", 32'(n_acc), 32'(NBUF));
    chk("bp_ready_low", 32'(REQ_READY), 0);
    popped.delete();
    drain();
    chk("bp_count", 32'(popped.size()), 32'(NBUF));
    for (int i = 0; i < popped.size(); i++) chk("bp_order", popped[i], 32'hC0DE0000 + 32'(i));
    // streaming
    rsp_ready = 1; n_acc = 0; run = 0; best = 0;
    for (int i = 0; i < 16 + LAT + 1; i++) begin
      req_valid = i < 16; req_we = 0; req_a = 13'(i % 16);
      step();
      if (last_acc) n_acc++;
      run = dut_v ? run + 1 : 0;
      if (run > best) best = run;
    end
    req_valid = 0;
    chk("stream_accepts", 32'(n_acc), 16);
    chk("stream_valid_run", 32'(best), 16);
    drain();
    // out of range
    req(1, 6000, 32'hDEADBEEF, 4'hF);
    req(0, 6000, 0, 0); drain();
    chk("oor_q", last_q, 0);
    chk("oor_err", 32'(last_e), 1);
    req(0, 5999, 0, 0); drain();
    chk("edge_q", last_q, 32'hC0DE0000 + 32'd5999);
    chk("edge_err", 32'(last_e), 0);
    // reset with responses buffered
    rsp_ready = 0;
    req(0, 0, 0, 0); req(0, 1, 0, 0);
    step(); step();
    rst = 1; step(); rst = 0;
    chk("midreset_valid", 32'(RSP_VALID), 0);
    req(0, 5, 0, 0); drain();
    chk("midreset_mem_kept", last_q, 32'hAA22CC44);
    // random
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 79) == 0;
      req_valid = 1'($urandom_range(0, 1));
      req_we = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 5998 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      req_a = 13'(a);
      req_d = $urandom;
      req_ben = 4'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    rst = 0; req_valid = 0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
